elevador_planta: RTL and testbench
==================================

# elevador_planta

Behavioural plant model of the four-floor elevator shaft, cab and door: the other end of the control block's interface. It consumes the controller's `motor1`/`motor2`/`porta` commands and produces the floor sensors `sen1..sen4` and the door sensor `sp` the controller reads. It sits under the top level in simulation and FPGA demo builds so the controller can be exercised in closed loop without hardware.

## Interface
- `FLOOR_TICKS`, 8: clock cycles of travel between adjacent floors (≥2).
- `DOOR_TICKS`, 4: clock cycles for a full door open or close stroke (≥1).
- `START_FLOOR`, 0: floor (0..3) the cab occupies after reset.
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `motor1`  in  1  1 = drive cab down.
- `motor2`  in  1  1 = drive cab up.
- `porta`  in  1  door command: 1 = open, 0 = close.
- `sen1..sen4`  out  1 each  floor sensor: high only while the cab is exactly aligned at floor 1..4.
- `sp`  out  1  door sensor: 1 whenever the door is not fully closed.
- `andar`  out  2  last floor aligned (0..3), held between floors.
- `falha`  out  1  sticky fault flag; cleared only by reset.

## Operation
- Position register `pos`, 0..3·FLOOR_TICKS, one unit per cycle of travel. Floor k (0..3) is aligned when `pos == k·FLOOR_TICKS`.
- Sensors and `andar` are decoded from registered `pos`. At most one `sen` is high. All are low between floors.
- Motion, evaluated every rising edge:
  - `motor2 & ~motor1` (up): `pos+1`, if door state is FECHADA and `pos < 3·FLOOR_TICKS`.
  - `motor1 & ~motor2` (down): `pos−1`, if door state is FECHADA and `pos > 0`.
  - Neither motor: hold.
- Motion faults set `falha` and hold `pos`:
  - both motors high;
  - a motor high while the door is not FECHADA;
  - up at `pos = 3·FLOOR_TICKS`;
  - down at `pos = 0`.
- Door FSM states: FECHADA, ABRINDO, ABERTA, FECHANDO. Counter `dcnt` (0..DOOR_TICKS).
  - FECHADA, `porta=1`, cab aligned at a floor, both motors low: go to ABRINDO, `dcnt←DOOR_TICKS`.
  - FECHADA, `porta=1` while between floors or with a motor active: stay FECHADA and set `falha`.
  - ABRINDO: `dcnt` decrements each cycle. Going to 0 moves to ABERTA. If `porta=0` mid-stroke, go to FECHANDO with `dcnt←DOOR_TICKS`.
  - ABERTA, `porta=0`: go to FECHANDO, `dcnt←DOOR_TICKS`.
  - FECHANDO: `dcnt` decrements each cycle. Going to 0 moves to FECHADA. If `porta=1` mid-stroke, go to ABRINDO with `dcnt←DOOR_TICKS`.
- `sp` = (door state ≠ FECHADA), registered with the state.
- Simultaneous door request and motor drive in FECHADA: the motor takes priority, the door stays closed, and `falha` is set.

## Timing
- Reset (asynchronous, immediate):
  - `pos = START_FLOOR·FLOOR_TICKS`;
  - door FECHADA, `dcnt=0`;
  - `sp=0`, `falha=0`, `andar=START_FLOOR`;
  - the matching `sen` high, all others low.
- Reset mid-travel or mid-door-stroke abandons the operation. The cab is returned to the reset floor.
- Latency:
  - A motor command sampled at edge n changes `pos` at edge n.
  - The first departure leaves `sen` low after that edge.
  - Arrival at the next floor takes exactly FLOOR_TICKS edges of continuous drive.
- Door:
  - `sp` rises on the edge that enters ABRINDO.
  - `sp` falls on the edge FECHANDO→FECHADA, DOOR_TICKS+1 edges after the closing command is sampled.
  - Full open stroke: DOOR_TICKS+1 edges from the FECHADA edge to ABERTA.
- `falha` rises on the edge at which the fault is sampled and then stays high.
- Direction reversal between floors is legal: `pos` turns around on the next edge with no fault.

## Test plan
- Reset with START_FLOOR=0, then `motor2=1` for 8 edges → `sen1` falls after edge 1 and `sen2` rises after edge 8. Release after edge 8 and `andar=1`; `falha=0`.
- At floor 4, `motor2=1` for 3 edges → `pos` holds, `sen4=1`, `falha=1` after the first edge.
- At floor 2 stopped, `porta=1` → `sp=1` after 1 edge and ABERTA after 5 edges. Then `porta=0` → `sp=0` 5 edges later.
- With the door ABERTA, `motor1=1` → `pos` unchanged, `falha=1`, `sen2` stays high.
- Mid-travel (pos=4), drive `motor1=motor2=1` → `pos` stays 4 and `falha=1`. Assert `reset` asynchronously between edges → `pos=0`, `sen1=1`, `falha=0` without waiting for a clock edge.

Source files
------------

// File: rtl/elevador_planta.sv
// elevador_planta: closed-loop plant model of a four-floor elevator cab and door.
module elevador_planta #(
  parameter int FLOOR_TICKS = 8,
  parameter int DOOR_TICKS  = 4,
  parameter int START_FLOOR = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       motor1,
  input  logic       motor2,
  input  logic       porta,
  output logic       sen1,
  output logic       sen2,
  output logic       sen3,
  output logic       sen4,
  output logic       sp,
  output logic [1:0] andar,
  output logic       falha
);
  localparam int PW = $clog2(3 * FLOOR_TICKS + 1);
  localparam int DW = $clog2(DOOR_TICKS + 1);
  localparam logic [PW-1:0] F1  = PW'(FLOOR_TICKS);
  localparam logic [PW-1:0] F2  = PW'(2 * FLOOR_TICKS);
  localparam logic [PW-1:0] TOP = PW'(3 * FLOOR_TICKS);
  localparam logic [PW-1:0] P0  = PW'(START_FLOOR * FLOOR_TICKS);
  localparam logic [DW-1:0] DT  = DW'(DOOR_TICKS);
  localparam logic [DW-1:0] D1  = DW'(1);
  typedef enum logic [1:0] {FECHADA, ABRINDO, ABERTA, FECHANDO} door_t;
  door_t st;
  logic [DW-1:0] dcnt;
  logic [PW-1:0] pos, pos_n;
  logic up, dn, any, closed, aligned, fault_m, fault_d;
  assign sen1 = pos == '0;
  assign sen2 = pos == F1;
  assign sen3 = pos == F2;
  assign sen4 = pos == TOP;
  always_comb begin
    up      = motor2 & ~motor1;
    dn      = motor1 & ~motor2;
    any     = motor1 | motor2;
    closed  = st == FECHADA;
    aligned = sen1 | sen2 | sen3 | sen4;
    fault_m = (motor1 & motor2) | (any & ~closed) | (up & sen4) | (dn & sen1);
    fault_d = closed & porta & (~aligned | any);
    pos_n   = (up & closed & ~sen4) ? pos + 1'b1 : (dn & closed & ~sen1) ? pos - 1'b1 : pos;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos   <= P0;
      st    <= FECHADA;
      dcnt  <= '0;
      sp    <= 1'b0;
      falha <= 1'b0;
      andar <= 2'(START_FLOOR);
    end else begin
      pos   <= pos_n;
      falha <= falha | fault_m | fault_d;
      andar <= (pos_n == '0) ? 2'd0 : (pos_n == F1) ? 2'd1 : (pos_n == F2) ? 2'd2 :
               (pos_n == TOP) ? 2'd3 : andar;
      // a reversal mid-stroke restarts the full stroke time
      case (st)
        FECHADA: if (porta & aligned & ~any) begin
          st   <= ABRINDO;
          dcnt <= DT;
          sp   <= 1'b1;
        end
        ABRINDO: if (!porta) begin
          st   <= FECHANDO;
          dcnt <= DT;
        end else begin
          dcnt <= dcnt - 1'b1;
          if (dcnt == D1) st <= ABERTA;
        end
        ABERTA: if (!porta) begin
          st   <= FECHANDO;
          dcnt <= DT;
        end
        FECHANDO: if (porta) begin
          st   <= ABRINDO;
          dcnt <= DT;
        end else begin
          dcnt <= dcnt - 1'b1;
          if (dcnt == D1) begin
            st <= FECHADA;
            sp <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_elevador_planta.sv
// tb_elevador_planta: randomized closed-loop stimulus with a queued reference-model scoreboard.
module tb_elevador_planta;
  localparam int F = 8, D = 4, S = 0;
  logic clock = 0, reset = 1, motor1 = 0, motor2 = 0, porta = 0;
  logic sen1, sen2, sen3, sen4, sp, falha;
  logic [1:0] andar;
  elevador_planta #(.FLOOR_TICKS(F), .DOOR_TICKS(D), .START_FLOOR(S)) dut (
    .clock(clock), .reset(reset), .motor1(motor1), .motor2(motor2), .porta(porta),
    .sen1(sen1), .sen2(sen2), .sen3(sen3), .sen4(sen4), .sp(sp), .andar(andar), .falha(falha)
  );
  always #5 clock = ~clock;
  typedef struct packed {logic [3:0] sen; logic [1:0] andar; logic sp; logic falha;} obs_t;
  typedef enum {CLOSED, OPENING, OPEN, CLOSING} door_e;
  obs_t q[$];
  int vectors = 0, miscompares = 0;
  int m_pos, m_andar, m_left;
  bit m_falha;
  door_e m_door;
  function automatic obs_t observe();
    return {sen4, sen3, sen2, sen1, andar, sp, falha};
  endfunction
  function automatic obs_t model_out();
    obs_t o;
    o.sen   = (m_pos % F == 0) ? 4'(1 << (m_pos / F)) : 4'b0;
    o.andar = 2'(m_andar);
    o.sp    = m_door != CLOSED;
    o.falha = m_falha;
    return o;
  endfunction
  function automatic void model_reset();
    m_pos = S * F; m_andar = S; m_door = CLOSED; m_left = 0; m_falha = 0;
  endfunction
  function automatic void model_step(bit m1, bit m2, bit p);
    bit closed = m_door == CLOSED;
    bit aligned = m_pos % F == 0;
    bit up = m2 && !m1, dn = m1 && !m2;
    if ((m1 && m2) || ((m1 || m2) && !closed) || (up && m_pos == 3 * F) || (dn && m_pos == 0)) m_falha = 1;
    if (closed && p && (!aligned || m1 || m2)) m_falha = 1;
    if (up && closed && m_pos < 3 * F) m_pos++;
    else if (dn && closed && m_pos > 0) m_pos--;
    if (m_pos % F == 0) m_andar = m_pos / F;
    case (m_door)
      CLOSED:  if (p && aligned && !m1 && !m2) begin m_door = OPENING; m_left = D; end
      OPENING: if (!p) begin m_door = CLOSING; m_left = D; end
               else begin m_left--; if (m_left == 0) m_door = OPEN; end
      OPEN:    if (!p) begin m_door = CLOSING; m_left = D; end
      CLOSING: if (p) begin m_door = OPENING; m_left = D; end
               else begin m_left--; if (m_left == 0) m_door = CLOSED; end
    endcase
  endfunction
  task automatic check(string name, obs_t got, obs_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got sen=%b andar=%0d sp=%b falha=%b, expected sen=%b andar=%0d sp=%b falha=%b",
               name, $time, got.sen, got.andar, got.sp, got.falha, exp.sen, exp.andar, exp.sp, exp.falha);
    end
  endtask
  task automatic apply(bit m1, bit m2, bit p, int n);
    repeat (n) begin
      @(negedge clock);
      motor1 = m1; motor2 = m2; porta = p;
      model_step(m1, m2, p);
      q.push_back(model_out());
    end
  endtask
  // reset is raised between edges and checked before any edge can occur
  task automatic do_reset();
    @(posedge clock);
    #2;
    motor1 = 0; motor2 = 0; porta = 0; reset = 1;
    #1;
    model_reset();
    check("async_reset", observe(), model_out());
    @(negedge clock);
    reset = 0;
  endtask
  initial begin : monitor
    forever begin
      @(posedge clock);
      #1;
      if (q.size() != 0) check("cycle", observe(), q.pop_front());
    end
  end
  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end
  initial begin : stimulus
    #3;
    model_reset();
    check("power_on_reset", observe(), model_out());
    @(negedge clock);
    reset = 0;
    apply(0, 1, 0, 8);  apply(0, 0, 0, 2);
    apply(0, 1, 0, 16); apply(0, 1, 0, 3);
    do_reset();
    apply(0, 1, 0, 8);  apply(0, 0, 1, 6); apply(0, 0, 0, 6);
    apply(0, 0, 1, 6);  apply(1, 0, 1, 2); apply(0, 0, 0, 6);
    do_reset();
    apply(0, 1, 0, 4);  apply(1, 1, 0, 2);
    do_reset();
    for (int e = 0; e < 25; e++) begin
      for (int a = 0; a < 40; a++) begin
        int r = $urandom_range(0, 9);
        if (r < 4) apply(0, 1, 0, $urandom_range(1, F + 3));
        else if (r < 7) apply(1, 0, 0, $urandom_range(1, F + 3));
        else if (r == 7) begin
          apply(0, 0, 1, $urandom_range(1, D + 3));
          apply(0, 0, 0, $urandom_range(1, D + 3));
        end else if (r == 8) apply(0, 0, 0, $urandom_range(1, 3));
        else apply(1'($urandom), 1'($urandom), 1'($urandom), 1);
      end
      do_reset();
    end
    @(posedge clock);
    #2;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
